// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state enum, bus widths and misalignment mask for the data-memory responder
package dmem_pkg;
  localparam int WORD_BITS = 32;
  localparam int ADDR_BITS = 8;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: non-reset single-port word array; ports clk, we, idx, wdata in, registered rdata out
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 64,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IW-1:0]        idx,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);
  logic [WORD_BITS-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with valid/ready request, one-cycle response pulse and pipeline stall
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [WORD_BITS-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 stall
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  dmem_state_t state, state_nx;
  logic [3:0] cnt;
  logic wr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WORD_BITS-1:0] wdata_q, arr_rdata;
  logic [IW-1:0] idx;
  logic accept, fire, misaligned;
  assign accept = state == IDLE && req_valid;
  assign fire = state == WAIT && cnt == 4'd0;
  assign misaligned = |(addr_q[1:0] & MISALIGN_MASK);
  // word index wraps modulo DEPTH, which also covers non-power-of-two depths
  assign idx = IW'({1'b0, addr_q[7:2]} % 7'(DEPTH));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? WAIT : IDLE) : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt <= 4'(LATENCY - 1);
      wr_q <= req_write;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
  // the array reads every cycle; the value captured on the edge entering RESP is the load result
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(fire && wr_q && !misaligned),
    .idx(idx),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_err = resp_valid && misaligned;
  assign resp_rdata = resp_valid && !wr_q && !misaligned ? arr_rdata : '0;
  assign stall = accept || state == WAIT;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table plus scoreboard checks for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid, req_write, req_ready, resp_valid, resp_err, stall;
  logic [7:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic v1, w1, ready1, rv1, er1, st1;
  logic [7:0] a1;
  logic [31:0] d1, rd1;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [31:0] rdata; logic err; int acc;} exp_t;
  typedef struct {logic wr; logic [7:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic err;} vec_t;
  exp_t q[$];
  int resp_cycles[$];
  logic [31:0] exp_rdata;
  logic exp_err;
  vec_t vecs[13];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_responder #(.DEPTH(64), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );
  dmem_responder #(.DEPTH(64), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_write(w1), .req_addr(a1),
    .req_wdata(d1), .req_ready(ready1), .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(er1), .stall(st1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (resp_valid) begin
        if (q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("latency", 32'(cyc - e.acc), 32'd2);
          resp_cycles.push_back(cyc);
        end
      end
      if (req_valid && req_ready) q.push_back('{exp_rdata, exp_err, cyc + 1});
    end
  end
  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask
  task automatic set_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input logic [31:0] er, input logic ee);
    req_write = wr;
    req_addr = addr;
    req_wdata = wd;
    exp_rdata = er;
    exp_err = ee;
    req_valid = 1'b1;
  endtask
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input logic [31:0] er, input logic ee);
    set_req(wr, addr, wd, er, ee);
    wait_accept();
    req_valid = 1'b0;
    wait_drain();
  endtask
  task automatic issue1(input logic wr, input logic [7:0] addr, input logic [31:0] wd, input logic [31:0] er);
    int n = 0;
    w1 = wr;
    a1 = addr;
    d1 = wd;
    v1 = 1'b1;
    @(negedge clk);
    while (!ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(negedge clk);
    chk("lat1_early", {31'd0, rv1}, 32'd0);
    @(negedge clk);
    chk("lat1_resp", {31'd0, rv1}, 32'd1);
    chk("lat1_rdata", rd1, er);
    chk("lat1_err", {31'd0, er1}, 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 8'h20, 32'h20202020, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 8'h08, 32'h00000808, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 8'h04, 32'h44444444, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 8'h20, 32'h0, 32'h20202020, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 32'h0F0F0F0F, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 8'h3C, 32'h0, 32'h0F0F0F0F, 1'b0};
    vecs[8]  = '{1'b1, 8'h21, 32'h12345678, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 8'h20, 32'h0, 32'h20202020, 1'b0};
    vecs[10] = '{1'b0, 8'h22, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 8'hFC, 32'hFFFF0000, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 8'hFC, 32'h0, 32'hFFFF0000, 1'b0};
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    exp_rdata = '0; exp_err = 1'b0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
    set_req(1'b0, 8'h04, 32'h0, 32'h44444444, 1'b0);
    @(negedge clk);
    chk("prof_stall_idle", {31'd0, stall}, 32'd1);
    chk("prof_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("prof_stall_wait", {31'd0, stall}, 32'd1);
      chk("prof_ready_wait", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("prof_stall_resp", {31'd0, stall}, 32'd0);
    chk("prof_ready_resp", {31'd0, req_ready}, 32'd0);
    chk("prof_valid_resp", {31'd0, resp_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_drain();
    set_req(1'b1, 8'h08, 32'hAAAA5555, 32'h0, 1'b0);
    wait_accept();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_err", {31'd0, resp_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 8'h08, 32'h0, 32'h00000808, 1'b0);
    resp_cycles.delete();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_req(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        1: set_req(1'b0, 8'h20, 32'h0, 32'h20202020, 1'b0);
        default: set_req(1'b0, 8'h04, 32'h0, 32'h44444444, 1'b0);
      endcase
      wait_accept();
      req_write = 1'b1;
      req_addr = 8'h3C;
      req_wdata = $urandom;
      if (i == 2) req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_drain();
    chk("b2b_count", 32'(resp_cycles.size()), 32'd3);
    if (resp_cycles.size() == 3) begin
      chk("b2b_gap1", 32'(resp_cycles[1] - resp_cycles[0]), 32'd4);
      chk("b2b_gap2", 32'(resp_cycles[2] - resp_cycles[1]), 32'd4);
    end
    issue(1'b0, 8'h3C, 32'h0, 32'h0F0F0F0F, 1'b0);
    issue1(1'b1, 8'h0C, 32'hCAFEF00D, 32'h0);
    issue1(1'b0, 8'h0C, 32'h0, 32'hCAFEF00D);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined CPU's MEM stage. It accepts one load/store request at a time over a valid/ready handshake and models a multi-cycle memory with a fixed wait-state count. It returns read data with a one-cycle response pulse and drives a stall to freeze the pipeline while an access is outstanding. It replaces the zero-latency data bank on the CPU's data-memory port.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; word index is `req_addr[7:2]`.
- `LATENCY`, 2: wait-state cycles per access. Legal range 1..15.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: MEM stage has a request (MemRead or MemWrite asserted).
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, 8: byte address (ALU result [7:0]).
- `req_wdata`, in, 32: store data (rt value).
- `req_ready`, out, 1: responder can accept a request this cycle.
- `resp_valid`, out, 1: one-cycle completion pulse.
- `resp_rdata`, out, 32: load data. It is 0 for stores and errors.
- `resp_err`, out, 1: misaligned address; valid with `resp_valid`.
- `stall`, out, 1: freezes PC, IF/ID, ID/EX and EX/MEM registers.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, the block latches `req_write`, `req_addr` and `req_wdata`, loads `cnt`=LATENCY-1, and moves to WAIT.
- **WAIT**
  - `req_ready`=0.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0, perform the access at that clock edge and move to RESP:
    - Store: write the latched data to `mem[addr[7:2]]`.
    - Load: register `mem[addr[7:2]]` into `resp_rdata`.
- **RESP**
  - `resp_valid`=1 for exactly one cycle, then return to IDLE.
  - `req_ready`=0, so a request presented in RESP is ignored.
  - The pipeline advances in this cycle. It re-presents any next request in the following IDLE cycle.
- **stall** = (IDLE & `req_valid`) | WAIT. It is deasserted in RESP.
- **Misalignment:** `addr[1:0]`≠0 means no array read or write. The access still takes the full latency, then returns `resp_err`=1 and `resp_rdata`=0.
- **Address range:** word index ≥ DEPTH is impossible for DEPTH=64. For a smaller DEPTH, the index wraps modulo DEPTH.
- **Latched request:** inputs are sampled only at the acceptance edge. Changes to `req_*` during WAIT or RESP have no effect.
- **Array contents:** the memory array is not reset. Contents are X until written. Reset does not alter the stored data.

## Timing
- **Reset values:** `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `stall`=0 (when `req_valid`=0). State is IDLE and `cnt`=0.
- **Latency:** request accepted at edge T → `resp_valid` high in the cycle after edge T+LATENCY. The total cycle count is LATENCY+1 cycles after acceptance.
- **Throughput:** one access per LATENCY+2 cycles when requests are presented back-to-back.
- **Write commit:** a store commits at the edge that enters RESP. A load issued after that edge sees the new data.
- **Reset mid-access:** asserting `rst_n`=0 in WAIT aborts the access. No write occurs, outputs return to their reset values immediately (asynchronously), and there is no `resp_valid`.
- **Simultaneous events:**
  - `req_valid` with `rst_n` low: ignored.
  - `req_valid` falling while in WAIT: the access still completes.

## Structure
- Package `dmem_pkg` holds:
  - the state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - the constants `WORD_BITS`=32 and `ADDR_BITS`=8;
  - the misalignment mask 2'b11.
- Sub-module `dmem_array` is a synchronous, non-reset single-port 32-bit × DEPTH array. It has ports `clk`, `we`, `idx`, `wdata` and a registered `rdata`.
- The FSM, counter and request latch live in the top module.

## Test plan
- **Store then load:** reset, then store 0xDEADBEEF to addr 0x10 and load addr 0x10 → `resp_rdata`=0xDEADBEEF. `resp_valid` occurs 3 cycles after each acceptance (LATENCY=2).
- **Stall profile:** single load at 0x04 → `stall`=1 for 3 cycles (IDLE-request cycle plus 2 WAIT cycles), 0 in the RESP cycle. `req_ready`=0 from WAIT through RESP.
- **Misaligned store:** store 0x12345678 to 0x21 → `resp_err`=1, `resp_rdata`=0. A following aligned load of 0x20 returns its prior value, unchanged.
- **Reset mid-access:** store 0xAAAA5555 to 0x08, pull `rst_n` low in the first WAIT cycle → no `resp_valid`, outputs at reset values. A later load of 0x08 returns its prior value.
- **Back-to-back requests:** hold `req_valid` continuously over 3 loads with addresses changing during WAIT → exactly 3 `resp_valid` pulses spaced 4 cycles apart. Each returns data for the address sampled at its acceptance.
- **LATENCY=1 build:** store then load → `resp_valid` 2 cycles after acceptance, with correct data.
